// File: rtl/clk_div_prog_tick.sv
// ---------------------------------------------------------------------------
// clk_div_prog_tick
//
// Clock-enable generator with a divisor that can be changed at run time.
// It divides clk by N (2 .. 2^DIV_W-1) and produces three outputs:
//   - tick     : a one-cycle enable pulse at the start of every period. The
//                downstream counter stage consumes this pulse.
//   - clk_out  : a registered divided clock with roughly 50% duty.
//   - tick_cnt : a free-running count of ticks, modulo 2^CNT_W.
//
// A new divisor is loaded into a shadow register first. It moves into the
// active divisor only on a period wrap, so a period is never cut short or
// stretched part-way through.
//
// Optional feature (macro CLK_DIV_PROG_ODD_DUTY50_EN):
//   When the macro is defined, a negedge flop copies clk_out. For odd
//   divisors the output is the OR of the posedge register and that copy,
//   which gives an exact 50% duty cycle. When the macro is undefined,
//   clk_out is the plain posedge register and no negedge logic exists.
//
// Parameters:
//   DIV_W   : width of the divisor and of the phase counter
//   DEF_DIV : divisor after reset (2 .. 2^DIV_W-1)
//   CNT_W   : width of tick_cnt
//
// Ports:
//   clk      in   system clock; all state changes on posedge
//   rst      in   asynchronous, active-low reset
//   en       in   count enable; while low, the phase counter and outputs hold
//   div_val  in   requested divisor
//   div_load in   one-cycle strobe that samples div_val
//   busy     out  a loaded divisor is waiting for the next wrap
//   load_err out  one-cycle pulse: a div_val below 2 was rejected
//   tick     out  one-cycle pulse at the start of each period
//   clk_out  out  divided clock (registered)
//   tick_cnt out  tick counter, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module clk_div_prog_tick #(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 4,
    parameter int CNT_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             busy,
    output logic             load_err,
    output logic             tick,
    output logic             clk_out,
    output logic [CNT_W-1:0] tick_cnt
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] cnt;      // phase within the current period
    logic [DIV_W-1:0] div_reg;  // divisor in force for the current period
    logic [DIV_W-1:0] shadow;   // pending divisor, valid while busy = 1
    logic             clk_pos;  // posedge-registered divided clock

    // -----------------------------------------------------------------------
    // Next-state decode
    // -----------------------------------------------------------------------
    logic             wrap;     // this edge ends a period
    logic             apply;    // this wrap also installs the shadow divisor
    logic             load_ok;  // accepted load request
    logic             load_bad; // rejected load request (divisor < 2)
    logic [DIV_W-1:0] cnt_new;
    logic [DIV_W-1:0] div_new;

    // NOTE: every signal written in this block gets a value on every path.
    // A path that skips an assignment would make synthesis infer a latch.
    always_comb begin
        wrap     = en && (cnt == div_reg - DIV_W'(1));
        apply    = wrap && busy;
        load_ok  = div_load && (div_val >= DIV_W'(2));
        load_bad = div_load && (div_val <  DIV_W'(2));
        cnt_new  = wrap ? '0 : cnt + DIV_W'(1);
        // The clk_out decode on a wrap edge has to use the divisor that
        // takes effect on that same edge.
        div_new  = apply ? shadow : div_reg;
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    // NOTE: use non-blocking assignments for all flop state. Every read in
    // this block then sees the value from before the edge, whatever the
    // order of the statements.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // cnt starts on the last phase, so the first enabled edge wraps
            // and issues a tick immediately.
            cnt      <= DIV_W'(DEF_DIV - 1);
            div_reg  <= DIV_W'(DEF_DIV);
            shadow   <= '0;
            busy     <= 1'b0;
            load_err <= 1'b0;
            tick     <= 1'b0;
            clk_pos  <= 1'b0;
            tick_cnt <= '0;
        end else begin
            tick     <= wrap;
            load_err <= load_bad;

            if (en) begin
                cnt     <= cnt_new;
                clk_pos <= (cnt_new < (div_new >> 1));
            end

            if (wrap) begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end

            if (apply) begin
                div_reg <= shadow;
            end

            // If a load arrives on an apply edge, div_reg takes the old
            // shadow value above. The new value then becomes the pending
            // one, so busy stays set.
            if (load_ok) begin
                shadow <= div_val;
                busy   <= 1'b1;
            end else if (apply) begin
                busy   <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output clock shaping
    // -----------------------------------------------------------------------
`ifdef CLK_DIV_PROG_ODD_DUTY50_EN
    // The negedge copy lags clk_pos by half a clock period. For odd N, the
    // OR of the two extends the high phase from (N-1)/2 to N/2 periods.
    logic clk_neg;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            clk_neg <= 1'b0;
        end else begin
            clk_neg <= clk_pos;
        end
    end

    assign clk_out = div_reg[0] ? (clk_pos | clk_neg) : clk_pos;
`else
    assign clk_out = clk_pos;
`endif

endmodule

// File: tb/tb_clk_div_prog_tick.sv
// ---------------------------------------------------------------------------
// tb_clk_div_prog_tick
//
// Directed testbench for clk_div_prog_tick in its default build (odd-duty
// macro undefined). Each scenario starts from a fresh reset. Outputs are
// sampled 1 ns after the posedge. "Cycle k" means the state just after the
// k-th enabled posedge that follows reset release.
// ---------------------------------------------------------------------------
module tb_clk_div_prog_tick;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] div_val;
    logic       div_load;
    logic       busy;
    logic       load_err;
    logic       tick;
    logic       clk_out;
    logic [1:0] tick_cnt;

    int checks = 0;
    int errors = 0;

    clk_div_prog_tick #(
        .DIV_W  (8),
        .DEF_DIV(4),
        .CNT_W  (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_val (div_val),
        .div_load(div_load),
        .busy    (busy),
        .load_err(load_err),
        .tick    (tick),
        .clk_out (clk_out),
        .tick_cnt(tick_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two clocks, then release it away from a clock edge.
    task automatic do_reset();
        en       = 1'b0;
        div_load = 1'b0;
        div_val  = 8'd0;
        rst      = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        en       = 1'b0;
        div_load = 1'b0;
        div_val  = 8'd0;
        rst      = 1'b0;
        step();
        checks++; if (tick !== 1'b0)     begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
        checks++; if (clk_out !== 1'b0)  begin errors++; $display("FAIL reset_clk_out: got %b want 0", clk_out); end
        checks++; if (tick_cnt !== 2'd0) begin errors++; $display("FAIL reset_tick_cnt: got %0d want 0", tick_cnt); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err: got %b want 0", load_err); end
    endtask

    // Default divisor of 4: tick on cycles 1, 5, 9, 13. clk_out follows
    // 1100, and tick_cnt steps 1, 2, 3, 0.
    task automatic test_default_div();
        logic       exp_t;
        logic       exp_c;
        logic [1:0] exp_n;
        do_reset();
        en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            exp_t = ((k - 1) % 4) == 0;
            exp_c = ((k - 1) % 4) < 2;
            exp_n = 2'(((k - 1) / 4) + 1);
            checks++; if (tick !== exp_t)     begin errors++; $display("FAIL def_tick c%0d: got %b want %b", k, tick, exp_t); end
            checks++; if (clk_out !== exp_c)  begin errors++; $display("FAIL def_clk_out c%0d: got %b want %b", k, clk_out, exp_c); end
            checks++; if (tick_cnt !== exp_n) begin errors++; $display("FAIL def_tick_cnt c%0d: got %0d want %0d", k, tick_cnt, exp_n); end
        end
    endtask

    // Load 3 in the middle of a period. busy stays high until the wrap on
    // cycle 5. After that, tick and clk_out both follow 100.
    task automatic test_load_three();
        logic exp_t;
        do_reset();
        en = 1'b1;
        step();                            // c1: wrap
        step();                            // c2
        div_val = 8'd3; div_load = 1'b1;
        step();                            // c3: load accepted
        div_load = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load3_busy c3: got %b want 1", busy); end
        step();                            // c4
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load3_busy c4: got %b want 1", busy); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL load3_tick c4: got %b want 0", tick); end
        step();                            // c5: wrap applies 3
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL load3_busy c5: got %b want 0", busy); end
        checks++; if (tick !== 1'b1)    begin errors++; $display("FAIL load3_tick c5: got %b want 1", tick); end
        checks++; if (clk_out !== 1'b1) begin errors++; $display("FAIL load3_clk_out c5: got %b want 1", clk_out); end
        for (int j = 0; j < 9; j++) begin
            step();
            exp_t = (j % 3) == 2;
            checks++; if (tick !== exp_t)    begin errors++; $display("FAIL load3_tick +%0d: got %b want %b", j, tick, exp_t); end
            checks++; if (clk_out !== exp_t) begin errors++; $display("FAIL load3_clk_out +%0d: got %b want %b", j, clk_out, exp_t); end
        end
    endtask

    // div_val = 1 and then 0 are both rejected. load_err pulses for one
    // cycle each time, busy stays low, and the period stays at 4.
    task automatic test_bad_load();
        logic exp_t;
        do_reset();
        en = 1'b1;
        step();                            // c1
        div_val = 8'd1; div_load = 1'b1;
        step();                            // c2
        div_load = 1'b0;
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL bad1_load_err: got %b want 1", load_err); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL bad1_busy: got %b want 0", busy); end
        step();                            // c3
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL bad1_pulse_width: got %b want 0", load_err); end
        div_val = 8'd0; div_load = 1'b1;
        step();                            // c4
        div_load = 1'b0;
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL bad0_load_err: got %b want 1", load_err); end
        step();                            // c5: wrap at the old period
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL bad0_pulse_width: got %b want 0", load_err); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL bad0_busy: got %b want 0", busy); end
        checks++; if (tick !== 1'b1)     begin errors++; $display("FAIL bad_tick c5: got %b want 1", tick); end
        for (int k = 6; k <= 9; k++) begin
            step();
            exp_t = (k == 9);
            checks++; if (tick !== exp_t) begin errors++; $display("FAIL bad_tick c%0d: got %b want %b", k, tick, exp_t); end
        end
    endtask

    // Load 5 and then 7 before the next wrap. Only 7 takes effect: ticks
    // come every 7 cycles and clk_out is high for 3 cycles, low for 4.
    task automatic test_back_to_back();
        logic exp_t;
        logic exp_c;
        do_reset();
        en = 1'b1;
        step();                            // c1
        div_val = 8'd5; div_load = 1'b1;
        step();                            // c2
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy c2: got %b want 1", busy); end
        div_val = 8'd7;
        step();                            // c3: overwrites the shadow
        div_load = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy c3: got %b want 1", busy); end
        step();                            // c4
        step();                            // c5: wrap applies 7
        checks++; if (tick !== 1'b1)    begin errors++; $display("FAIL b2b_tick c5: got %b want 1", tick); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL b2b_busy c5: got %b want 0", busy); end
        checks++; if (clk_out !== 1'b1) begin errors++; $display("FAIL b2b_clk_out c5: got %b want 1", clk_out); end
        for (int j = 0; j < 14; j++) begin
            step();
            exp_t = (j % 7) == 6;
            exp_c = ((j % 7) == 6) || ((j % 7) < 2);
            checks++; if (tick !== exp_t)    begin errors++; $display("FAIL b2b_tick +%0d: got %b want %b", j, tick, exp_t); end
            checks++; if (clk_out !== exp_c) begin errors++; $display("FAIL b2b_clk_out +%0d: got %b want %b", j, clk_out, exp_c); end
        end
    endtask

    // Hold en low for 6 cycles while clk_out is high, and load a divisor
    // during the hold. Outputs freeze and busy stays set. When en returns,
    // the phase resumes at cnt = 2 and wraps two edges later.
    task automatic test_enable_hold();
        do_reset();
        en = 1'b1;
        step();                            // c1: cnt 0
        step();                            // c2: cnt 1, clk_out 1
        en = 1'b0;
        for (int j = 0; j < 6; j++) begin
            div_val  = 8'd4;
            div_load = (j == 0);
            step();
            checks++; if (tick !== 1'b0)     begin errors++; $display("FAIL hold_tick h%0d: got %b want 0", j, tick); end
            checks++; if (clk_out !== 1'b1)  begin errors++; $display("FAIL hold_clk_out h%0d: got %b want 1", j, clk_out); end
            checks++; if (tick_cnt !== 2'd1) begin errors++; $display("FAIL hold_tick_cnt h%0d: got %0d want 1", j, tick_cnt); end
            checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL hold_busy h%0d: got %b want 1", j, busy); end
        end
        div_load = 1'b0;
        en = 1'b1;
        step();                            // cnt 2
        checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL resume_clk_out r1: got %b want 0", clk_out); end
        checks++; if (tick !== 1'b0)    begin errors++; $display("FAIL resume_tick r1: got %b want 0", tick); end
        step();                            // cnt 3
        checks++; if (tick !== 1'b0)    begin errors++; $display("FAIL resume_tick r2: got %b want 0", tick); end
        step();                            // wrap
        checks++; if (tick !== 1'b1)     begin errors++; $display("FAIL resume_tick r3: got %b want 1", tick); end
        checks++; if (tick_cnt !== 2'd2) begin errors++; $display("FAIL resume_tick_cnt r3: got %0d want 2", tick_cnt); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL resume_busy r3: got %b want 0", busy); end
    endtask

    // Assert reset between edges while busy = 1 and clk_out = 1. Outputs
    // clear at once. After release the period is back to 4 and the pending
    // load of 3 is gone.
    task automatic test_reset_mid();
        logic exp_t;
        logic exp_c;
        do_reset();
        en = 1'b1;
        step();                            // c1
        div_val = 8'd3; div_load = 1'b1;
        step();                            // c2: busy 1, clk_out 1
        div_load = 1'b0;
        checks++; if (busy !== 1'b1 || clk_out !== 1'b1) begin errors++; $display("FAIL rstmid_pre: busy=%b clk_out=%b want 1 1", busy, clk_out); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (clk_out !== 1'b0)  begin errors++; $display("FAIL rstmid_clk_out: got %b want 0", clk_out); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (tick_cnt !== 2'd0) begin errors++; $display("FAIL rstmid_tick_cnt: got %0d want 0", tick_cnt); end
        step();
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_t = ((k - 1) % 4) == 0;
            exp_c = ((k - 1) % 4) < 2;
            checks++; if (tick !== exp_t)    begin errors++; $display("FAIL rstmid_tick c%0d: got %b want %b", k, tick, exp_t); end
            checks++; if (clk_out !== exp_c) begin errors++; $display("FAIL rstmid_clk_out c%0d: got %b want %b", k, clk_out, exp_c); end
            checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rstmid_busy c%0d: got %b want 0", k, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_load_three();
        test_bad_load();
        test_back_to_back();
        test_enable_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_prog_tick.md
Name: clk_div_prog_tick

Overview:
- Runtime-programmable integer clock-enable generator.
- Divides clk by N (2..2^DIV_W-1) and produces:
  - a one-cycle tick pulse per period;
  - a registered divided clock clk_out, roughly 50% duty;
  - a free-running tick counter.
- Sits directly upstream of the fixed divide-by-4 counter stage, replacing its hard-wired 0..3 counter and flag with a loadable divisor. tick is the enable that the downstream counter consumes.

Parameters:
- DIV_W, 8, width of the divisor and of the internal phase counter.
- DEF_DIV, 4, divisor after reset; must be 2..2^DIV_W-1.
- CNT_W, 2, width of tick_cnt; wraps modulo 2^CNT_W.

Ports:
- clk  in  1  system clock; all state on posedge, plus one negedge flop under the optional feature.
- rst  in  1  asynchronous, active-low reset; assertion clears state immediately, release is synchronous to clk.
- en  in  1  count enable; when low, the phase counter and outputs hold.
- div_val  in  DIV_W  requested divisor.
- div_load  in  1  one-cycle strobe; samples div_val.
- busy  out  1  a loaded divisor is pending and not yet applied.
- load_err  out  1  one-cycle pulse; div_val < 2 was rejected.
- tick  out  1  one-cycle pulse at each period start.
- clk_out  out  1  divided clock, registered.
- tick_cnt  out  CNT_W  counts ticks.

Behaviour:
- Reset values:
  - cnt = DEF_DIV-1, div_reg = DEF_DIV.
  - shadow = 0, busy = 0, load_err = 0.
  - tick = 0, clk_out = 0, tick_cnt = 0.
- Phase counter cnt (DIV_W bits), on each posedge with en=1:
  - if cnt == div_reg-1: cnt <= 0 (wrap);
  - else: cnt <= cnt+1.
  - With en=0, cnt holds.
- tick (registered):
  - Set to 1 on exactly the edge where the wrap occurs; 0 on all other edges, including every edge with en=0.
  - tick is therefore high in the cycle where cnt==0 following a wrap.
  - The first enabled edge after reset release wraps, so tick=1 and cnt=0 one cycle after the first en=1 edge.
- clk_out (registered):
  - On each enabled edge, clk_out <= (cnt_new < (div_new>>1)), where cnt_new and div_new are the values being written on that edge.
  - Even N: high N/2 cycles, low N/2.
  - Odd N without the optional feature: high (N-1)/2, low (N+1)/2.
  - Rises on the same edge tick asserts.
  - Holds when en=0.
- tick_cnt: increments by 1 on each edge where tick is being set; wraps from 2^CNT_W-1 to 0.
- Load handshake:
  - div_load=1 with div_val >= 2: shadow <= div_val, busy <= 1.
  - div_load=1 with div_val < 2: load_err pulses 1 the next cycle; shadow and busy are unchanged.
  - A new valid load while busy=1 overwrites shadow; last value wins and busy stays 1.
- Apply:
  - On a wrap edge with busy=1: div_reg <= shadow, busy <= 0, and that wrap's clk_out decode uses the new divisor.
  - If div_load arrives on the same edge as a wrap, the old shadow (if busy) is applied and the new value becomes pending.
  - The divisor never changes mid-period.
  - If en=0, busy stays 1 until the next enabled wrap.
- Reset mid-operation: all state returns to reset values asynchronously; any pending load is discarded.
- No combinational path from any input to any output.

Optional Feature:
- Macro: CLK_DIV_PROG_ODD_DUTY50_EN.
- Defined:
  - A negedge flop samples clk_out.
  - For odd div_reg, the output is clk_out OR the negedge copy, giving exactly 50% duty (high N/2 clock periods).
  - Even N is unaffected; the negedge flop resets to 0.
- Undefined: clk_out is the plain posedge register with the odd-N duty stated above. No negedge logic is synthesised.

Test Plan:
- Reset, en=1, DEF_DIV=4:
  - tick at cycles 1, 5, 9, 13;
  - clk_out pattern 1100 repeating;
  - tick_cnt steps 1, 2, 3, 0.
- div_load with div_val=3 mid-period:
  - busy=1 until the next wrap;
  - after it, tick every 3 cycles;
  - clk_out 100 repeating (macro off); high 1.5 cycles with the macro on.
- div_val=1, then div_val=0:
  - load_err pulses one cycle each;
  - busy stays 0; period stays 4.
- Loads of 5 then 7 before a wrap: only 7 is applied; tick spacing becomes 7, clk_out high 3 / low 4.
- en low for 6 cycles mid-period:
  - cnt, clk_out and tick_cnt frozen, tick=0;
  - phase resumes exactly where it stopped.
- rst asserted while busy=1 and clk_out=1:
  - outputs clear immediately;
  - after release, period reverts to DEF_DIV=4 and busy=0.
